// File: rtl/meas_engine_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : meas_engine_scheduler
// Purpose  : Queues run requests for the three measurement engines (analog
//            preview, digital period/high-time, digital protocol capture),
//            grants one engine at a time round-robin, routes the shared
//            front-end, drives the start/ready/ack handshake, holds the
//            result for the host and aborts hung runs.
// Revision : 1.0 - initial release
// ============================================================================
module meas_engine_scheduler #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int RELEASE_MAX    = 1024
) (
  input  logic       HCLK,
  input  logic       AHB2HRESETn,
  input  logic [2:0] req_pulse,
  input  logic       cancel,
  output logic [2:0] eng_start,
  input  logic [2:0] eng_ready,
  output logic [2:0] eng_ack,
  output logic [1:0] mux_sel,
  output logic [1:0] active_id,
  output logic [2:0] pending,
  output logic       busy,
  output logic       host_done,
  input  logic       host_ack,
  output logic       timeout_flag,
  input  logic       timeout_clr
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  localparam logic [31:0] c_settle_last  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] c_release_last = 32'(RELEASE_MAX - 1);

  state_t      r_state, w_state;
  logic [1:0]  r_rr_last, w_rr_last;
  logic [31:0] r_cnt, w_cnt;
  logic [2:0]  r_pending, w_pending;
  logic [2:0]  r_eng_start, w_eng_start;
  logic [2:0]  r_eng_ack, w_eng_ack;
  logic [1:0]  r_mux_sel, w_mux_sel;
  logic [1:0]  r_active_id, w_active_id;
  logic        r_busy;
  logic        r_host_done, w_host_done;
  logic        r_timeout_flag;

  logic [2:0]  w_act_mask;
  logic        w_ready_act;
  logic [1:0]  w_cand1, w_cand2, w_winner;
  logic [2:0]  w_grant_mask;
  logic        w_flush;
  logic        w_to_set;

  // Modulo-3 increment of an engine index.
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // One-hot mask of the granted engine (zero while idle, active_id = 3).
  assign w_act_mask  = 3'b001 << r_active_id;
  assign w_ready_act = |(eng_ready & w_act_mask);

  // Round-robin search order: rr_last+1, rr_last+2, rr_last.
  assign w_cand1  = inc3(r_rr_last);
  assign w_cand2  = inc3(w_cand1);
  assign w_winner = |(r_pending & (3'b001 << w_cand1)) ? w_cand1 :
                    |(r_pending & (3'b001 << w_cand2)) ? w_cand2 : r_rr_last;

  // Next-state and output decode.
  always_comb begin
    w_state      = r_state;
    w_rr_last    = r_rr_last;
    w_cnt        = r_cnt;
    w_eng_start  = r_eng_start;
    w_eng_ack    = 3'b000;
    w_mux_sel    = r_mux_sel;
    w_active_id  = r_active_id;
    w_host_done  = r_host_done;
    w_grant_mask = 3'b000;
    w_flush      = 1'b0;
    w_to_set     = 1'b0;

    if (cancel && (r_state == S_SETTLE || r_state == S_RUN || r_state == S_DONE)) begin
      // Abort: always ack so a half-finished engine gets cleared.
      w_flush     = 1'b1;
      w_eng_start = 3'b000;
      w_host_done = 1'b0;
      w_eng_ack   = w_act_mask;
      w_state     = S_ACK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cancel) begin
            w_flush = 1'b1;
          end else if (r_pending != 3'b000) begin
            w_grant_mask = 3'b001 << w_winner;
            w_active_id  = w_winner;
            w_mux_sel    = w_winner + 2'd1;
            w_rr_last    = w_winner;
            w_cnt        = 32'd0;
            w_state      = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == c_settle_last) begin
            w_eng_start = w_act_mask;
            w_cnt       = 32'd0;
            w_state     = S_RUN;
          end else begin
            w_cnt = r_cnt + 32'd1;
          end
        end
        S_RUN: begin
          // Ready has priority over a timeout landing in the same cycle.
          if (w_ready_act) begin
            w_host_done = 1'b1;
            w_state     = S_DONE;
          end else if (r_cnt == c_timeout_last) begin
            w_eng_start = 3'b000;
            w_eng_ack   = w_act_mask;
            w_to_set    = 1'b1;
            w_state     = S_ACK;
          end else begin
            w_cnt = r_cnt + 32'd1;
          end
        end
        S_DONE: begin
          if (host_ack) begin
            w_host_done = 1'b0;
            w_eng_start = 3'b000;
            w_eng_ack   = w_act_mask;
            w_state     = S_ACK;
          end
        end
        S_ACK: begin
          w_flush = cancel;
          w_cnt   = 32'd0;
          w_state = S_RELEASE;
        end
        S_RELEASE: begin
          w_flush = cancel;
          if (!w_ready_act || r_cnt == c_release_last) begin
            w_to_set    = w_ready_act;
            w_mux_sel   = 2'd0;
            w_active_id = 2'd3;
            w_state     = S_IDLE;
          end else begin
            w_cnt = r_cnt + 32'd1;
          end
        end
        default: begin
          w_state     = S_IDLE;
          w_eng_start = 3'b000;
          w_mux_sel   = 2'd0;
          w_active_id = 2'd3;
          w_host_done = 1'b0;
        end
      endcase
    end

    // A new request beats a same-cycle grant; cancel drops everything.
    w_pending = w_flush ? 3'b000 : ((r_pending & ~w_grant_mask) | req_pulse);
  end

  // State and registered outputs.
  always_ff @(posedge HCLK or negedge AHB2HRESETn) begin
    if (!AHB2HRESETn) begin
      r_state        <= S_IDLE;
      r_rr_last      <= 2'd2;
      r_cnt          <= 32'd0;
      r_pending      <= 3'b000;
      r_eng_start    <= 3'b000;
      r_eng_ack      <= 3'b000;
      r_mux_sel      <= 2'd0;
      r_active_id    <= 2'd3;
      r_busy         <= 1'b0;
      r_host_done    <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_rr_last      <= w_rr_last;
      r_cnt          <= w_cnt;
      r_pending      <= w_pending;
      r_eng_start    <= w_eng_start;
      r_eng_ack      <= w_eng_ack;
      r_mux_sel      <= w_mux_sel;
      r_active_id    <= w_active_id;
      r_busy         <= (w_state != S_IDLE);
      r_host_done    <= w_host_done;
      r_timeout_flag <= (r_timeout_flag & ~timeout_clr) | w_to_set;
    end
  end

  assign eng_start    = r_eng_start;
  assign eng_ack      = r_eng_ack;
  assign mux_sel      = r_mux_sel;
  assign active_id    = r_active_id;
  assign pending      = r_pending;
  assign busy         = r_busy;
  assign host_done    = r_host_done;
  assign timeout_flag = r_timeout_flag;

endmodule
`default_nettype wire

// File: tb/tb_meas_engine_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_meas_engine_scheduler
// Purpose  : Self-checking bench for meas_engine_scheduler. Expected grant
//            order is queued when requests are driven and compared when a
//            start rises; handshake timing is checked cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_meas_engine_scheduler;

  logic       HCLK = 1'b0;
  logic       AHB2HRESETn;
  logic [2:0] req_pulse;
  logic       cancel;
  logic [2:0] eng_start;
  logic [2:0] eng_ready;
  logic [2:0] eng_ack;
  logic [1:0] mux_sel;
  logic [1:0] active_id;
  logic [2:0] pending;
  logic       busy;
  logic       host_done;
  logic       host_ack;
  logic       timeout_flag;
  logic       timeout_clr;

  int n_cmp = 0;
  int n_err = 0;
  int sb_q[$];
  logic [2:0] prev_start = 3'b000;

  always #5 HCLK = ~HCLK;

  meas_engine_scheduler #(
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(100),
    .RELEASE_MAX   (16)
  ) dut (
    .HCLK        (HCLK),
    .AHB2HRESETn (AHB2HRESETn),
    .req_pulse   (req_pulse),
    .cancel      (cancel),
    .eng_start   (eng_start),
    .eng_ready   (eng_ready),
    .eng_ack     (eng_ack),
    .mux_sel     (mux_sel),
    .active_id   (active_id),
    .pending     (pending),
    .busy        (busy),
    .host_done   (host_done),
    .host_ack    (host_ack),
    .timeout_flag(timeout_flag),
    .timeout_clr (timeout_clr)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  // Scoreboard: every rising start is compared with the next queued grant.
  always @(posedge HCLK) begin
    #1;
    if (prev_start == 3'b000 && eng_start != 3'b000) begin
      check_val("sb_onehot", $countones(eng_start), 1);
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_grant", {29'd0, eng_start}, 0);
      end else begin
        int e;
        e = sb_q.pop_front();
        check_val("sb_grant", {29'd0, eng_start}, 32'(3'b001 << e));
        check_val("sb_mux", {30'd0, mux_sel}, 32'(e + 1));
      end
    end
    prev_start = eng_start;
  end

  task automatic do_reset;
    AHB2HRESETn = 1'b0;
    req_pulse   = 3'b000;
    cancel      = 1'b0;
    eng_ready   = 3'b000;
    host_ack    = 1'b0;
    timeout_clr = 1'b0;
    repeat (2) tick;
    AHB2HRESETn = 1'b1;
    tick;
  endtask

  task automatic pulse_req(input logic [2:0] r);
    req_pulse = r;
    tick;
    req_pulse = 3'b000;
  endtask

  task automatic wait_start(output int id);
    id = -1;
    for (int i = 0; i < 60; i++) begin
      if (eng_start != 3'b000) break;
      tick;
    end
    check_val("start_seen", {31'd0, (eng_start != 3'b000)}, 1);
    for (int k = 0; k < 3; k++)
      if (eng_start[k]) id = k;
  endtask

  // Full handshake for the next granted engine; 'extra' is pulsed mid-run.
  task automatic run_one(input logic [2:0] extra, output int id);
    wait_start(id);
    if (id < 0) return;
    if (extra != 3'b000) pulse_req(extra);
    eng_ready[id] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (host_done) break;
      tick;
    end
    check_val("run_host_done", {31'd0, host_done}, 1);
    check_val("run_active_id", {30'd0, active_id}, 32'(id));
    host_ack = 1'b1;
    tick;
    host_ack = 1'b0;
    check_val("run_eng_ack", {29'd0, eng_ack}, 32'(3'b001 << id));
    check_val("run_start_low", {29'd0, eng_start}, 0);
    tick;
    check_val("run_ack_one_cycle", {29'd0, eng_ack}, 0);
    eng_ready[id] = 1'b0;
    tick;
    check_val("run_idle_busy", {31'd0, busy}, 0);
    check_val("run_idle_active", {30'd0, active_id}, 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int id, k;

    // Reset values while reset is held.
    do_reset;
    AHB2HRESETn = 1'b0;
    #2;
    check_val("rst_active_id", {30'd0, active_id}, 3);
    check_val("rst_busy", {31'd0, busy}, 0);
    check_val("rst_start", {29'd0, eng_start}, 0);
    check_val("rst_pending", {29'd0, pending}, 0);
    check_val("rst_flag", {31'd0, timeout_flag}, 0);
    do_reset;

    // Single run, cycle-exact.
    sb_q.push_back(0);
    pulse_req(3'b001);
    check_val("t1_pending", {29'd0, pending}, 1);
    check_val("t1_busy0", {31'd0, busy}, 0);
    tick;
    check_val("t1_mux", {30'd0, mux_sel}, 1);
    check_val("t1_active", {30'd0, active_id}, 0);
    check_val("t1_busy1", {31'd0, busy}, 1);
    check_val("t1_pending_clr", {29'd0, pending}, 0);
    repeat (3) tick;
    check_val("t1_settle_hold", {29'd0, eng_start}, 0);
    tick;
    check_val("t1_start", {29'd0, eng_start}, 1);
    eng_ready[0] = 1'b1;
    tick;
    check_val("t1_done", {31'd0, host_done}, 1);
    repeat (3) tick;
    check_val("t1_done_hold", {31'd0, host_done}, 1);
    check_val("t1_start_hold", {29'd0, eng_start}, 1);
    host_ack = 1'b1;
    tick;
    host_ack = 1'b0;
    check_val("t1_ack", {29'd0, eng_ack}, 1);
    check_val("t1_done_clr", {31'd0, host_done}, 0);
    tick;
    check_val("t1_ack_end", {29'd0, eng_ack}, 0);
    check_val("t1_release_busy", {31'd0, busy}, 1);
    eng_ready[0] = 1'b0;
    tick;
    check_val("t1_idle_busy", {31'd0, busy}, 0);
    check_val("t1_idle_mux", {30'd0, mux_sel}, 0);
    check_val("t1_idle_active", {30'd0, active_id}, 3);

    // Round-robin: two bursts of all three requests.
    do_reset;
    for (int b = 0; b < 2; b++) begin
      sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(2);
      pulse_req(3'b111);
      check_val("rr_pending", {29'd0, pending}, 7);
      for (int e = 0; e < 3; e++) begin
        run_one(3'b000, id);
        check_val("rr_order", 32'(id), 32'(e));
      end
    end

    // Fairness: engine 1 re-requested during its own run while 2 is queued.
    do_reset;
    sb_q.push_back(1); sb_q.push_back(2); sb_q.push_back(1);
    pulse_req(3'b010);
    run_one(3'b110, id);
    check_val("fair_first", 32'(id), 1);
    run_one(3'b000, id);
    check_val("fair_second", 32'(id), 2);
    run_one(3'b000, id);
    check_val("fair_third", 32'(id), 1);

    // Run timeout: ready never rises.
    do_reset;
    sb_q.push_back(0);
    pulse_req(3'b001);
    wait_start(id);
    k = 0;
    for (int i = 0; i < 300; i++) begin
      if (eng_start == 3'b000) break;
      tick;
      k++;
    end
    check_val("to_len", 32'(k), 100);
    check_val("to_flag", {31'd0, timeout_flag}, 1);
    check_val("to_ack", {29'd0, eng_ack}, 1);
    tick;
    check_val("to_ack_end", {29'd0, eng_ack}, 0);
    tick;
    check_val("to_idle", {31'd0, busy}, 0);
    check_val("to_flag_sticky", {31'd0, timeout_flag}, 1);
    timeout_clr = 1'b1;
    tick;
    timeout_clr = 1'b0;
    check_val("to_flag_clr", {31'd0, timeout_flag}, 0);

    // Release timeout: ready stays high after the ack.
    sb_q.push_back(1);
    pulse_req(3'b010);
    wait_start(id);
    eng_ready[1] = 1'b1;
    tick;
    host_ack = 1'b1;
    tick;
    host_ack = 1'b0;
    check_val("rel_ack", {29'd0, eng_ack}, 2);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      tick;
      k++;
    end
    check_val("rel_len", 32'(k), 17);
    check_val("rel_flag", {31'd0, timeout_flag}, 1);
    eng_ready[1] = 1'b0;
    timeout_clr = 1'b1;
    tick;
    timeout_clr = 1'b0;

    // Cancel in DONE with two requests pending; a coincident request is dropped.
    do_reset;
    sb_q.push_back(0);
    pulse_req(3'b001);
    wait_start(id);
    eng_ready[0] = 1'b1;
    tick;
    check_val("cx_done", {31'd0, host_done}, 1);
    pulse_req(3'b110);
    check_val("cx_pending", {29'd0, pending}, 6);
    cancel    = 1'b1;
    req_pulse = 3'b001;
    tick;
    cancel    = 1'b0;
    req_pulse = 3'b000;
    check_val("cx_done_clr", {31'd0, host_done}, 0);
    check_val("cx_ack", {29'd0, eng_ack}, 1);
    check_val("cx_pending_clr", {29'd0, pending}, 0);
    check_val("cx_start_low", {29'd0, eng_start}, 0);
    eng_ready[0] = 1'b0;
    repeat (2) tick;
    check_val("cx_idle", {31'd0, busy}, 0);
    repeat (20) tick;
    check_val("cx_no_grant", {31'd0, busy}, 0);
    check_val("cx_no_pending", {29'd0, pending}, 0);

    // Asynchronous reset mid-run, then analog priority restored.
    sb_q.push_back(1);
    pulse_req(3'b010);
    wait_start(id);
    pulse_req(3'b001);
    #3;
    AHB2HRESETn = 1'b0;
    #1;
    check_val("ar_start", {29'd0, eng_start}, 0);
    check_val("ar_pending", {29'd0, pending}, 0);
    check_val("ar_busy", {31'd0, busy}, 0);
    check_val("ar_active", {30'd0, active_id}, 3);
    tick;
    AHB2HRESETn = 1'b1;
    tick;
    sb_q.push_back(0); sb_q.push_back(1);
    pulse_req(3'b011);
    run_one(3'b000, id);
    check_val("ar_first", 32'(id), 0);
    run_one(3'b000, id);
    check_val("ar_second", 32'(id), 1);

    repeat (3) tick;
    check_val("sb_drain", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
